axi_lite_slave_regs: RTL
========================

# axi_lite_slave_regs

AXI4-Lite responder that terminates the write-address, write-data, write-response, read-address and read-data channels and maps them onto a bank of NUM_REGS 32-bit read/write control registers. It is the target-side counterpart to the team's AXI-Lite master and sits directly on that master's bus. The register contents are exported as a flat bus to downstream logic.

## Interface
- NUM_REGS, 4: number of 32-bit registers, at byte offsets 4*i; legal range 1..16.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  reset; one clock, synchronous, active-high.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  32  write byte address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte-lane enables; bit k covers WDATA[8k+7:8k].
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  32  read byte address.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  32  read data.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- REGS_OUT  out  32*NUM_REGS  register i on bits [32i+31:32i].

## Operation
- Decode: index = ADDR[31:2]; ADDR[1:0] ignored. Index < NUM_REGS hits; otherwise miss (SLVERR).
- Write path, two capture flags aw_full, w_full:
  - AWREADY = !ARESET & !aw_full & !BVALID; WREADY = !ARESET & !w_full & !BVALID.
  - AW handshake latches AWADDR, sets aw_full. W handshake latches WDATA/WSTRB, sets w_full. Either order, any gap, or the same cycle.
  - Commit on the edge at which the second of the two handshakes completes, or on which both complete. At a hit, update each byte lane with its WSTRB bit set; at a miss, discard the data. Clear both flags, set BVALID, BRESP = OKAY (hit) or SLVERR (miss).
  - WSTRB = 0 at a hit: no register change, BRESP = OKAY.
  - BVALID and BRESP are held stable until BVALID & BREADY, then BVALID clears on that edge. No new AW/W are accepted while BVALID = 1.
- Read FSM, states R_IDLE and R_DATA:
  - ARREADY = !ARESET & (state == R_IDLE).
  - R_IDLE: on ARVALID, register RDATA (register value at a hit, 0 at a miss) and RRESP (OKAY or SLVERR), set RVALID, and go to R_DATA.
  - R_DATA: hold RVALID/RDATA/RRESP stable. On RREADY, clear RVALID and return to R_IDLE.
- The read and write paths are fully independent and run concurrently.
- Read and write commit on the same edge to the same register: RDATA returns the pre-write value.

## Timing
- Reset (ARESET high at an edge): all registers, REGS_OUT, aw_full, w_full, BVALID, BRESP, RVALID, RDATA and RRESP go to 0. The read FSM goes to R_IDLE. Ready outputs are 0 while ARESET is high.
- Reset mid-transaction: any partially captured AW/W and any pending B/R response is dropped. After reset, nothing is re-issued.
- Write latency: BVALID is high in the first cycle after the final AW/W handshake. REGS_OUT reflects the new value in that same cycle.
- Read latency: RVALID is high in the first cycle after the AR handshake.
- Throughput:
  - One write per 2 cycles minimum when BREADY is tied high (handshake cycle, then BVALID cycle).
  - One read per 2 cycles minimum when RREADY is tied high.
- VALID outputs never drop without the matching READY.
- AWREADY, WREADY and ARREADY are combinational from state only, never from the inputs, so there are no combinational loops with the master.

## Test plan
- Reset: hold ARESET 2 cycles with random inputs -> all outputs 0. After release, AWREADY = WREADY = ARREADY = 1, BVALID = RVALID = 0.
- Aligned write then read:
  - AW 0x4 and W 0xDEADBEEF with WSTRB 4'hF in the same cycle -> BVALID = 1 next cycle, BRESP = 00, REGS_OUT[63:32] = 0xDEADBEEF.
  - AR 0x4 -> RDATA = 0xDEADBEEF, RRESP = 00 one cycle later.
- Split, order and strobes:
  - Reg0 = 0x11223344. Write W 0xAABBCCDD, WSTRB 4'b0101, then AW 0x0 three cycles later -> WREADY low while waiting, BVALID 1 cycle after the AW handshake, reg0 = 0x11BB33DD.
- Out of range: NUM_REGS = 4.
  - Write to 0x10 -> BRESP = 10, no register changes.
  - Read 0x10 -> RDATA = 0, RRESP = 10.
- Backpressure:
  - BREADY low for 5 cycles -> BVALID/BRESP stable, AWREADY = WREADY = 0 throughout.
  - RREADY low for 5 cycles -> RVALID/RDATA stable, ARREADY = 0.
- Concurrency and mid-operation reset:
  - Write reg1 = 0x5 and read reg1 committing on the same edge (old value 0x0) -> RDATA = 0x0, later read = 0x5.
  - ARESET with AW captured but no W -> after reset, aw_full cleared and no BVALID ever appears.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_slave_regs
// Description : AXI4-Lite responder over a bank of NUM_REGS 32-bit R/W
//               registers, exported as a flat bus.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regs #(
    parameter int NUM_REGS = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [31:0]              ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [32*NUM_REGS-1:0]   REGS_OUT
);

    localparam logic [29:0] REG_COUNT  = 30'(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    logic [31:0] regs [NUM_REGS];

    logic        aw_full;
    logic        w_full;
    logic [29:0] aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [29:0] wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_hit;

    logic        rd_hit;
    logic [31:0] rd_word;

    rstate_t     r_state;
    rstate_t     r_state_nxt;

    // Byte-offset LSBs carry no meaning for word registers.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign AWREADY = !ARESET && !aw_full && !BVALID;
    assign WREADY  = !ARESET && !w_full && !BVALID;
    assign ARREADY = !ARESET && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);

    // Write side: whichever half arrives live this cycle bypasses its latch.
    always_comb begin
        aw_hs   = AWVALID && AWREADY;
        w_hs    = WVALID && WREADY;
        commit  = (aw_hs || aw_full) && (w_hs || w_full);
        wr_idx  = aw_full ? aw_idx : AWADDR[31:2];
        wr_data = w_full ? w_data : WDATA;
        wr_strb = w_full ? w_strb : WSTRB;
        wr_hit  = (wr_idx < REG_COUNT);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_hit && (wr_idx == 30'(i))) begin
                        for (int k = 0; k < 4; k++) begin
                            if (wr_strb[k]) begin
                                regs[i][8*k +: 8] <= wr_data[8*k +: 8];
                            end
                        end
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_idx  <= AWADDR[31:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= WDATA;
                    w_strb <= WSTRB;
                end
            end
        end
    end

    // Read side reads the registers before any same-edge write lands.
    always_comb begin
        rd_hit  = (ARADDR[31:2] < REG_COUNT);
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ARADDR[31:2] == 30'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ARVALID) r_state_nxt = R_DATA;
            R_DATA:  if (RREADY)  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if ((r_state == R_IDLE) && ARVALID) begin
            RDATA <= rd_hit ? rd_word : 32'h0;
            RRESP <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
            assign REGS_OUT[32*i +: 32] = regs[i];
        end
    endgenerate

endmodule
`default_nettype wire
